// File: rtl/hazard_fwd_scoreboard.sv
// Pipeline hazard unit with a shifting destination scoreboard: IF/ID stall, ID/EX bubble,
// and registered EXE operand-forwarding selects. A memory freeze holds all state.
module hazard_fwd_scoreboard #(
  parameter int REG_AW = 4,
  parameter int STAGES = 2,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  localparam int SW    = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_rn_used,
  input  logic [REG_AW-1:0] id_rdm,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              branch_taken,
  input  logic              mem_ready,
  output logic              hazard,
  output logic              freeze,
  output logic [SW-1:0]     fwd_sel_a,
  output logic [SW-1:0]     fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic LP_FWD = (FWD_EN != 0);

  // Entry 0 is the instruction now in EXE; higher indices are older.
  logic [STAGES-1:0]             r_sb_valid;
  logic [STAGES-1:0]             r_sb_wb;
  logic [STAGES-1:0]             r_sb_ld;
  logic [STAGES-1:0][REG_AW-1:0] r_sb_dest;
  logic [SW-1:0]                 r_sel_a;
  logic [SW-1:0]                 r_sel_b;
  logic [CNT_W-1:0]              r_cnt;

  logic [STAGES-1:0] w_match_a;
  logic [STAGES-1:0] w_match_b;
  logic              w_raw;
  logic              w_hazard;
  logic              w_bubble;
  logic [SW-1:0]     w_sel_a;
  logic [SW-1:0]     w_sel_b;

  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_match_a[k] = id_valid & id_rn_used & r_sb_valid[k] & r_sb_wb[k] & (r_sb_dest[k] == id_rn);
      w_match_b[k] = id_valid & id_two_src & r_sb_valid[k] & r_sb_wb[k] & (r_sb_dest[k] == id_rdm);
    end
  end

  assign w_raw    = LP_FWD ? ((w_match_a[0] | w_match_b[0]) & r_sb_ld[0]) : (|(w_match_a | w_match_b));
  assign w_hazard = w_raw & ~branch_taken & ~rst;
  assign w_bubble = w_hazard | branch_taken | ~id_valid;

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (w_match_a[k]) w_sel_a = SW'(k + 1);
      if (w_match_b[k]) w_sel_b = SW'(k + 1);
    end
    if (!LP_FWD || w_bubble) begin
      w_sel_a = '0;
      w_sel_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_valid <= '0;
      r_sb_wb    <= '0;
      r_sb_ld    <= '0;
      r_sb_dest  <= '0;
      r_sel_a    <= '0;
      r_sel_b    <= '0;
      r_cnt      <= '0;
    end else if (mem_ready) begin
      for (int k = 1; k < STAGES; k++) begin
        r_sb_valid[k] <= r_sb_valid[k-1];
        r_sb_wb[k]    <= r_sb_wb[k-1];
        r_sb_ld[k]    <= r_sb_ld[k-1];
        r_sb_dest[k]  <= r_sb_dest[k-1];
      end
      if (w_bubble) begin
        r_sb_valid[0] <= 1'b0;
        r_sb_wb[0]    <= 1'b0;
        r_sb_ld[0]    <= 1'b0;
        r_sb_dest[0]  <= '0;
      end else begin
        r_sb_valid[0] <= 1'b1;
        r_sb_wb[0]    <= id_wb_en;
        r_sb_ld[0]    <= id_mem_r_en;
        r_sb_dest[0]  <= id_dest;
      end
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
      if (w_hazard && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hazard    = w_hazard;
  assign freeze    = ~mem_ready;
  assign fwd_sel_a = r_sel_a;
  assign fwd_sel_b = r_sel_b;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard: three configurations share one ID stream and are
// compared every cycle against a list-of-in-flight-instructions model, plus literal pins.
module tb_hazard_fwd_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_rn_used, id_two_src, id_wb_en, id_mem_r_en;
  logic       branch_taken, mem_ready;
  logic [3:0] id_rn, id_rdm, id_dest;

  logic        haz0, haz1, haz2, frz0, frz1, frz2;
  logic [1:0]  sela0, selb0, sela1, selb1, sela2, selb2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  // u0: stall-only, u1: forwarding, u2: stall-only with 3 stages and a 4-bit counter
  hazard_fwd_scoreboard #(.REG_AW(4), .STAGES(2), .FWD_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
    .id_rdm(id_rdm), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .hazard(haz0), .freeze(frz0), .fwd_sel_a(sela0), .fwd_sel_b(selb0), .stall_cnt(cnt0));

  hazard_fwd_scoreboard #(.REG_AW(4), .STAGES(2), .FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
    .id_rdm(id_rdm), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .hazard(haz1), .freeze(frz1), .fwd_sel_a(sela1), .fwd_sel_b(selb1), .stall_cnt(cnt1));

  hazard_fwd_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
    .id_rdm(id_rdm), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .hazard(haz2), .freeze(frz2), .fwd_sel_a(sela2), .fwd_sel_b(selb2), .stall_cnt(cnt2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int tgt    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   ns[3]   = '{2, 2, 3};
  bit   fwd[3]  = '{1'b0, 1'b1, 1'b0};
  int   cmax[3] = '{65535, 65535, 15};
  logic       mv[3][4];
  logic       mw[3][4];
  logic       ml[3][4];
  logic [3:0] md[3][4];
  int         msa[3];
  int         msb[3];
  int         mcnt[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        mv[i][k] = 0; mw[i][k] = 0; ml[i][k] = 0; md[i][k] = 0;
      end
      msa[i] = 0; msb[i] = 0; mcnt[i] = 0;
    end
  end

  function automatic logic mm(int i, int k, logic [3:0] src, logic used);
    return id_valid && used && mv[i][k] && mw[i][k] && (md[i][k] == src);
  endfunction

  function automatic logic mdl_haz(int i);
    logic any = 1'b0;
    if (rst || branch_taken) return 1'b0;
    if (fwd[i]) return (mm(i, 0, id_rn, id_rn_used) || mm(i, 0, id_rdm, id_two_src)) && ml[i][0];
    for (int k = 0; k < ns[i]; k++)
      any = any | mm(i, k, id_rn, id_rn_used) | mm(i, k, id_rdm, id_two_src);
    return any;
  endfunction

  task automatic mdl_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          mv[i][k] = 0; mw[i][k] = 0; ml[i][k] = 0; md[i][k] = 0;
        end
        msa[i] = 0; msb[i] = 0; mcnt[i] = 0;
      end else if (mem_ready) begin
        logic h;
        logic bub;
        int   na;
        int   nb;
        h   = mdl_haz(i);
        bub = h || branch_taken || !id_valid;
        na  = 0;
        nb  = 0;
        if (fwd[i] && !bub) begin
          for (int k = 0; k < ns[i]; k++) begin
            if (na == 0 && mm(i, k, id_rn, id_rn_used)) na = k + 1;
            if (nb == 0 && mm(i, k, id_rdm, id_two_src)) nb = k + 1;
          end
        end
        msa[i] = na;
        msb[i] = nb;
        if (h && mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
        for (int k = ns[i] - 1; k > 0; k--) begin
          mv[i][k] = mv[i][k-1]; mw[i][k] = mw[i][k-1];
          ml[i][k] = ml[i][k-1]; md[i][k] = md[i][k-1];
        end
        mv[i][0] = !bub;
        mw[i][0] = bub ? 1'b0 : id_wb_en;
        ml[i][0] = bub ? 1'b0 : id_mem_r_en;
        md[i][0] = bub ? 4'd0 : id_dest;
      end
    end
  endtask

  always @(posedge clk) mdl_step();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int hz[3];
      int fz[3];
      int sa[3];
      int sb[3];
      int ct[3];
      hz = '{int'(haz0), int'(haz1), int'(haz2)};
      fz = '{int'(frz0), int'(frz1), int'(frz2)};
      sa = '{int'(sela0), int'(sela1), int'(sela2)};
      sb = '{int'(selb0), int'(selb1), int'(selb2)};
      ct = '{int'(cnt0), int'(cnt1), int'(cnt2)};
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("hazard_u%0d", i), hz[i], int'(mdl_haz(i)));
        chk($sformatf("freeze_u%0d", i), fz[i], int'(!mem_ready));
        chk($sformatf("sel_a_u%0d", i), sa[i], msa[i]);
        chk($sformatf("sel_b_u%0d", i), sb[i], msb[i]);
        chk($sformatf("cnt_u%0d", i), ct[i], mcnt[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(bit v, bit wb, bit ld, int dest, int rn, bit rnu, int rdm, bit two);
    id_valid = v; id_wb_en = wb; id_mem_r_en = ld; id_dest = 4'(dest);
    id_rn = 4'(rn); id_rn_used = rnu; id_rdm = 4'(rdm); id_two_src = two;
  endtask

  // Present an instruction and hold it in ID while the target configuration stalls.
  task automatic issue(bit wb, bit ld, int dest, int rn, bit rnu, int rdm, bit two);
    int n = 0;
    logic h;
    set_id(1'b1, wb, ld, dest, rn, rnu, rdm, two);
    do begin
      h = mdl_haz(tgt) || !mem_ready;
      cyc();
      n++;
    end while (h && n < 20);
    if (h) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout stalled_cycles=%0d limit=20", n);
    end
  endtask

  task automatic idle(int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_cnt", int'(cnt1), 0);
    chk("rst_sel_a", int'(sela1), 0);
    rst = 1'b0;

    // T1: stall-only, ADD r1 ; SUB r2,r1,r3
    tgt = 0;
    issue(1, 0, 1, 2, 1, 3, 1);
    issue(1, 0, 2, 1, 1, 3, 1);
    idle(3);
    chk("t1_cnt", int'(cnt0), 2);

    // T2: forwarding distance 1, distance 2, and tag 15
    do_reset(); tgt = 1;
    issue(1, 0, 1, 2, 1, 3, 1);
    issue(1, 0, 2, 1, 1, 3, 1);
    chk("t2_sel_a_d1", int'(sela1), 1);
    chk("t2_sel_b_d1", int'(selb1), 0);
    idle(3);
    issue(1, 0, 1, 2, 1, 3, 1);
    issue(1, 0, 6, 7, 1, 8, 1);
    issue(1, 0, 2, 1, 1, 3, 1);
    chk("t2_sel_a_d2", int'(sela1), 2);
    idle(3);
    issue(1, 0, 15, 2, 1, 3, 0);
    issue(1, 0, 3, 15, 1, 15, 1);
    chk("t2_pc_sel_a", int'(sela1), 1);
    chk("t2_pc_sel_b", int'(selb1), 1);
    idle(3);

    // T3: load-use, LDR r4 ; ADD r5,r4,r4
    do_reset(); tgt = 1;
    issue(1, 1, 4, 9, 1, 0, 0);
    issue(1, 0, 5, 4, 1, 4, 1);
    chk("t3_sel_a", int'(sela1), 2);
    chk("t3_sel_b", int'(selb1), 2);
    chk("t3_cnt", int'(cnt1), 1);
    idle(3);

    // T4: youngest producer wins; flush dominates a load-use hazard
    do_reset(); tgt = 1;
    issue(1, 0, 1, 2, 1, 3, 0);
    issue(1, 0, 1, 3, 1, 2, 0);
    issue(1, 0, 2, 1, 1, 0, 0);
    chk("t4_youngest", int'(sela1), 1);
    idle(3);
    issue(1, 1, 4, 9, 1, 0, 0);
    set_id(1, 1, 0, 4, 4, 1, 4, 1);
    branch_taken = 1'b1;
    @(negedge clk);
    chk("t4_flush_haz", int'(haz1), 0);
    cyc();
    branch_taken = 1'b0;
    issue(1, 0, 6, 4, 1, 0, 0);
    chk("t4_bubble_sel", int'(sela1), 2);
    idle(3);

    // T5: freeze during a stall-only stall
    do_reset(); tgt = 0;
    issue(1, 0, 1, 2, 1, 3, 1);
    set_id(1, 1, 0, 2, 1, 1, 3, 1);
    cyc();
    mem_ready = 1'b0;
    repeat (5) cyc();
    chk("t5_frozen_cnt", int'(cnt0), 1);
    chk("t5_frozen_sel", int'(sela1), 1);
    mem_ready = 1'b1;
    cyc();
    cyc();
    idle(2);
    chk("t5_cnt", int'(cnt0), 2);

    // T6: 4-bit counter saturates, then reset mid-stall
    do_reset(); tgt = 2;
    repeat (7) begin
      issue(1, 0, 1, 0, 0, 0, 0);
      issue(1, 0, 5, 1, 1, 0, 0);
    end
    idle(4);
    chk("t6_sat", int'(cnt2), 15);
    issue(1, 0, 1, 0, 0, 0, 0);
    set_id(1, 1, 0, 5, 1, 1, 0, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_haz", int'(haz2), 0);
    cyc();
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_rst_cnt2", int'(cnt2), 0);
    chk("t6_rst_cnt0", int'(cnt0), 0);
    chk("t6_rst_sel", int'(sela1), 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
